// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int DEF_DW        = 8;
  localparam int DEF_MAX_BURST = 4;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin picker: first set bit of eligible at or after ptr, cyclically.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  localparam logic [IDX_W:0] N_L = (IDX_W+1)'(N);

  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  // Rotate so ptr lands at bit 0, priority-encode, then rotate the index back.
  always_comb begin
    dbl   = {eligible, eligible};
    rot   = N'(dbl >> ptr);
    found = 1'b0;
    off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = IDX_W'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= N_L) begin
      sum = sum - N_L;
    end
    idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters,
// granting bounded bursts and throttling on full/afull.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int CNT_W     = 16
) (
  input  logic                       wr_clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DW-1:0]      req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         cfg_mask,
  input  logic                       full,
  input  logic                       afull,
  output logic                       wr_en,
  output logic [DW-1:0]              wr_data,
  output logic                       gnt_active,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic [CNT_W-1:0]           write_count
);

  localparam int IDX_W  = clog2_min1(NUM_REQ);
  localparam int BEAT_W = clog2_min1(MAX_BURST + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   gnt_id_q, gnt_id_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] eligible;
  logic               cur_valid;
  logic [IDX_W-1:0]   ptr_next;

  assign eligible = req_valid & ~cfg_mask;

  rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .eligible (eligible),
    .ptr      (ptr_q),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  // State and bookkeeping registers.
  always_ff @(posedge wr_clock) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      beat_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      beat_q   <= beat_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state: grant in IDLE, count beats and detect burst end in BURST.
  always_comb begin
    state_d  = state_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    beat_d   = beat_q;
    cnt_d    = cnt_q;
    ptr_next = (gnt_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!afull && pick_found) begin
          gnt_id_d = pick_idx;
          beat_d   = '0;
          state_d  = BURST;
        end
      end
      BURST: begin
        if (!cur_valid) begin
          // Requester ran dry: release the port without a write this cycle.
          state_d = IDLE;
          ptr_d   = ptr_next;
        end else if (wr_en) begin
          beat_d = beat_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (beat_q == BEAT_W'(MAX_BURST - 1)) begin
            state_d = IDLE;
            ptr_d   = ptr_next;
          end
        end
        // A full stall leaves everything held; the beat is retried.
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: write strobe and data mux are combinational from the grant.
  always_comb begin
    cur_valid   = req_valid[gnt_id_q];
    gnt_active  = (state_q == BURST);
    wr_en       = gnt_active & cur_valid & ~full;
    wr_data     = req_data[int'(gnt_id_q)*DW +: DW];
    req_ready   = wr_en ? (NUM_REQ'(1) << gnt_id_q) : '0;
    gnt_id      = gnt_id_q;
    write_count = cnt_q;
  end

endmodule
